// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, funct3 codes and FSM state type for the RV32M sequencer
package muldiv_pkg;
  localparam int XLEN = 32;
  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} md_state_t;
endpackage

// File: rtl/execute_muldiv_ctrl_if.sv
// execute_muldiv_ctrl_if: execute-stage <-> mul/div handshake
// master (execute stage) drives start/funct3/op_a/op_b/rd_in/flush; slave (sequencer) drives stall/result_valid/result/rd_out
interface execute_muldiv_ctrl_if
  import muldiv_pkg::*;
();
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            flush;
  logic            stall;
  logic            result_valid;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  modport master (output start, funct3, op_a, op_b, rd_in, flush, input stall, result_valid, result, rd_out);
  modport slave  (input start, funct3, op_a, op_b, rd_in, flush, output stall, result_valid, result, rd_out);
endinterface

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: optional two's-complement negate of a W-bit value
// i_val: value, i_neg: negate when 1, o_val: result
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);
  assign o_val = i_neg ? -i_val : i_val;
endmodule

// File: rtl/execute_muldiv_ctrl.sv
// execute_muldiv_ctrl: iterative RV32M multiply/divide sequencer with pipeline stall
// clk/rst_n: clock and async active-low reset; bus: execute-stage handshake (slave side)
module execute_muldiv_ctrl
  import muldiv_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  execute_muldiv_ctrl_if.slave bus
);
  md_state_t         r_state;
  logic [2:0]        r_f3;
  logic [4:0]        r_rd;
  logic              r_sa;
  logic              r_sb;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN:0]     r_rem;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_out;
  logic              r_valid;
  logic              w_sa;
  logic              w_sb;
  logic              w_accept;
  logic              w_div0;
  logic              w_ovf;
  logic              w_fast;
  logic              w_borrow;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [XLEN-1:0]   w_fast_res;
  logic [XLEN:0]     w_madd;
  logic [XLEN:0]     w_sh;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_p_fix;
  logic [XLEN-1:0]   w_q_fix;
  logic [XLEN-1:0]   w_r_fix;
  logic [XLEN-1:0]   w_res;
  assign w_sa = (bus.funct3 inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) & bus.op_a[XLEN-1];
  assign w_sb = (bus.funct3 inside {MD_MULH, MD_DIV, MD_REM}) & bus.op_b[XLEN-1];
  assign w_accept = bus.start & ~bus.flush & (r_state == IDLE || r_state == DONE);
  assign w_div0 = bus.funct3[2] & (bus.op_b == '0);
  assign w_ovf = (bus.funct3 inside {MD_DIV, MD_REM}) & (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) & (bus.op_b == '1);
  assign w_fast = w_div0 | w_ovf;
  // overflow case: op_a is the most-negative value, which is also the DIV answer
  assign w_fast_res = w_div0 ? (bus.funct3[1] ? bus.op_a : '1) : (bus.funct3[1] ? '0 : bus.op_a);
  muldiv_sign_fix #(.W(XLEN)) u_mag_a (.i_val(bus.op_a), .i_neg(w_sa), .o_val(w_mag_a));
  muldiv_sign_fix #(.W(XLEN)) u_mag_b (.i_val(bus.op_b), .i_neg(w_sb), .o_val(w_mag_b));
  // multiply: r_acc = {partial high, remaining multiplier bits}
  assign w_madd = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_acc[0] ? r_a : {XLEN{1'b0}}};
  // divide: r_acc[XLEN-1:0] shifts dividend bits out and quotient bits in
  assign w_sh = {r_rem[XLEN-1:0], r_acc[XLEN-1]};
  assign w_diff = w_sh - {1'b0, r_b};
  assign w_borrow = w_diff[XLEN] & ~r_rem[XLEN];
  muldiv_sign_fix #(.W(2*XLEN)) u_fix_p (.i_val(r_acc), .i_neg(r_sa ^ r_sb), .o_val(w_p_fix));
  muldiv_sign_fix #(.W(XLEN)) u_fix_q (.i_val(r_acc[XLEN-1:0]), .i_neg(r_sa ^ r_sb), .o_val(w_q_fix));
  muldiv_sign_fix #(.W(XLEN)) u_fix_r (.i_val(r_rem[XLEN-1:0]), .i_neg(r_sa), .o_val(w_r_fix));
  assign w_res = r_f3[2] ? (r_f3[1] ? w_r_fix : w_q_fix) : (r_f3[1:0] == 2'b00 ? w_p_fix[XLEN-1:0] : w_p_fix[2*XLEN-1:XLEN]);
  assign bus.stall = ~bus.flush & ((r_state == IDLE || r_state == DONE) ? bus.start : 1'b1);
  assign bus.result_valid = r_valid;
  assign bus.result = r_result;
  assign bus.rd_out = r_rd_out;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_f3 <= '0;
      r_rd <= '0;
      r_sa <= 1'b0;
      r_sb <= 1'b0;
      r_a <= '0;
      r_b <= '0;
      r_cnt <= '0;
      r_acc <= '0;
      r_rem <= '0;
      r_result <= '0;
      r_rd_out <= '0;
      r_valid <= 1'b0;
    end else if (bus.flush) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_f3 <= bus.funct3;
      r_rd <= bus.rd_in;
      r_sa <= w_sa;
      r_sb <= w_sb;
      r_a <= w_mag_a;
      r_b <= w_mag_b;
      r_cnt <= CNT_W'(XLEN);
      r_acc <= {{XLEN{1'b0}}, bus.funct3[2] ? w_mag_a : w_mag_b};
      r_rem <= '0;
      r_state <= w_fast ? DONE : CALC;
      r_valid <= w_fast;
      if (w_fast) begin
        r_result <= w_fast_res;
        r_rd_out <= bus.rd_in;
      end
    end else if (r_state == CALC) begin
      r_acc <= r_f3[2] ? {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-2:0], ~w_borrow} : {w_madd, r_acc[XLEN-1:1]};
      r_rem <= r_f3[2] ? (w_borrow ? w_sh : w_diff) : r_rem;
      r_cnt <= r_cnt - CNT_W'(1);
      r_state <= (r_cnt == CNT_W'(1)) ? FIXUP : CALC;
    end else if (r_state == FIXUP) begin
      r_result <= w_res;
      r_rd_out <= r_rd;
      r_valid <= 1'b1;
      r_state <= DONE;
    end else if (r_state == DONE) begin
      r_valid <= 1'b0;
      r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_execute_muldiv_ctrl.sv
// tb_execute_muldiv_ctrl: vector table, random ops vs arithmetic model, flush/back-to-back/reset sequences
module tb_execute_muldiv_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  execute_muldiv_ctrl_if bus();
  execute_muldiv_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t tbl[14];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    if (!f[2]) begin
      r = (f == 3'd2) ? sa * ub : (f == 3'd3) ? ua * ub : sa * sb;
      return (f == 3'd0) ? r[31:0] : r[63:32];
    end
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    r = f[0] ? (f[1] ? ua % ub : ua / ub) : (f[1] ? sa % sb : sa / sb);
    return r[31:0];
  endfunction
  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 34;
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat, input string nm);
    int lat = 0;
    int ns = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b; bus.rd_in = rd;
    @(negedge clk);
    chk({nm, " stall@accept"}, 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op_a = $urandom; bus.op_b = $urandom; bus.rd_in = 5'($urandom);
    for (int c = 1; c <= 100 && lat == 0; c++) begin
      @(negedge clk);
      if (bus.result_valid) lat = c;
      else ns += int'(bus.stall);
    end
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " stall cycles"}, 32'(ns), 32'(exp_lat - 1));
    chk({nm, " result"}, bus.result, exp);
    chk({nm, " rd_out"}, 32'(bus.rd_out), 32'(rd));
    chk({nm, " stall@done"}, 32'(bus.stall), 32'd0);
    @(negedge clk);
    chk({nm, " valid one cycle"}, 32'(bus.result_valid), 32'd0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat;
    int seen;
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0; bus.op_a = '0; bus.op_b = '0; bus.rd_in = '0;
    tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    tbl[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
    tbl[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34};
    tbl[4]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
    tbl[5]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34};
    tbl[6]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
    tbl[7]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
    tbl[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    tbl[9]  = '{3'd7, 32'd5,          32'd0,         32'd5,         1};
    tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    tbl[12] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
    tbl[13] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         34};
    repeat (2) @(posedge clk);
    #1;
    chk("reset result_valid", 32'(bus.result_valid), 32'd0);
    chk("reset result", bus.result, 32'd0);
    chk("reset rd_out", 32'(bus.rd_out), 32'd0);
    chk("reset stall", 32'(bus.stall), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++)
      run_op(tbl[i].f3, tbl[i].a, tbl[i].b, 5'(i + 1), tbl[i].exp, tbl[i].lat, $sformatf("vec%0d", i));
    for (int i = 0; i < 24; i++) begin
      logic [2:0] f;
      logic [31:0] a, b;
      f = 3'($urandom);
      a = pick();
      b = pick();
      run_op(f, a, b, 5'($urandom), model(f, a, b), model_lat(f, a, b), $sformatf("rnd%0d f3=%0d a=%h b=%h", i, f, a, b));
    end
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd5; bus.op_b = 32'd6; bus.rd_in = 5'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    chk("flush stall", 32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      seen |= int'(bus.result_valid) | int'(bus.stall);
    end
    chk("flush no valid/stall after", 32'(seen), 32'd0);
    run_op(3'd5, 32'd9, 32'd3, 5'd11, 32'd3, 34, "post-flush divu");
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd3; bus.op_b = 32'd4; bus.rd_in = 5'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.op_a = 32'd12; bus.op_b = 32'd4; bus.rd_in = 5'd6;
    @(negedge clk);
    chk("b2b first valid", 32'(bus.result_valid), 32'd1);
    chk("b2b first result", bus.result, 32'd12);
    chk("b2b first rd_out", 32'(bus.rd_out), 32'd5);
    chk("b2b stall held", 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 100 && lat == 0; c++) begin
      @(negedge clk);
      if (bus.result_valid) lat = c;
    end
    chk("b2b second latency", 32'(lat), 32'd34);
    chk("b2b second result", bus.result, 32'd3);
    chk("b2b second rd_out", 32'(bus.rd_out), 32'd6);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = 3'd3; bus.op_a = 32'hFFFF_FFFF; bus.op_b = 32'hFFFF_FFFF; bus.rd_in = 5'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midcalc reset result_valid", 32'(bus.result_valid), 32'd0);
    chk("midcalc reset result", bus.result, 32'd0);
    chk("midcalc reset rd_out", 32'(bus.rd_out), 32'd0);
    chk("midcalc reset stall", 32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFE, 34, "post-reset mulhu");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
